pts_sector_sched: RTL and testbench
===================================

// Module: pts_sector_sched
// PURPOSE
//  Sequences the 11-bit LiDAR point-count accumulator once per angular sector.
//  Gates its ce/A inputs from the point stream and clears it between sectors.
//  Captures each sector total into a small result FIFO read by the detection stage.
//  Sits between the point filter (ROI hit flag) and the car-detection logic.
// PARAMETERS
//  CNT_W        11  accumulator / count width
//  NUM_SECTORS  16  sectors per frame
//  SEC_W        4   sector index width, clog2(NUM_SECTORS)
//  FIFO_DEPTH   4   result FIFO entries (power of 2)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous reset, active-high
//  frame_start  in   1      1-cycle pulse: a new scan frame begins
//  pt_valid     in   1      point present on the stream
//  pt_hit       in   1      point lies in the ROI (counts when 1)
//  sector_end   in   1      qualifies the current beat as the last point of the sector
//  pt_ready     out  1      point accepted when pt_valid & pt_ready
//  acc_y        in   CNT_W  accumulator output (registered count)
//  acc_ce       out  1      accumulator clock enable
//  acc_rst      out  1      accumulator clear (synchronous to clk)
//  acc_a        out  1      accumulator increment bit
//  thresh       in   CNT_W  detection threshold (used only with PTS_THRESH_EN)
//  res_valid    out  1      result FIFO not empty
//  res_ready    in   1      consumer pops when res_valid & res_ready
//  res_count    out  CNT_W  sector point count
//  res_sector   out  SEC_W  sector index
//  res_ovf      out  1      count saturated in this sector
//  res_obj      out  1      count >= thresh (PTS_THRESH_EN only, else 0)
//  busy         out  1      FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; FIFO empty; sector index 0; ovf flag clear.
//  FSM states and transitions:
//   IDLE: pt_ready=0. frame_start -> CLEAR.
//   CLEAR: 1 cycle; acc_rst=1, sector index=0, ovf flag clear -> COUNT.
//   COUNT: pt_ready=1.
//    - On an accepted beat: acc_ce=1, acc_a=pt_hit.
//    - Accepted beat with sector_end=1 (counted) -> SETTLE.
//   SETTLE: 1 cycle; pt_ready=0, acc_ce=0. Lets acc_y reflect the last point -> CAPTURE.
//   CAPTURE: pt_ready=0. Waits while the FIFO is full. When space is available:
//    - push {sector, acc_y, ovf}; acc_rst=1; clear the ovf flag.
//    - Last sector (NUM_SECTORS-1) -> IDLE; otherwise increment sector -> COUNT.
//  Latency: sector_end beat -> FIFO entry visible (res_valid) 3 cycles later.
//   Timeline: edge1 acc update, edge2 SETTLE exit, edge3 push.
//  Saturation: an accepted beat with pt_hit=1 while acc_y == 2^CNT_W-1 drives
//   acc_ce=0 (no wrap) and sets the sticky ovf flag.
//  FIFO: res_* shows the head entry. Push and pop in the same cycle are both allowed,
//   including when full (pop frees the slot first). Outputs are registered; no X when empty.
//  frame_start outside IDLE: abort. The partial sector is discarded -> CLEAR.
//   Queued FIFO entries are kept.
//  frame_start coinciding with a CAPTURE push: the push completes, then CLEAR.
//  Async rst mid-operation: immediate return to the reset state; FIFO contents lost.
//  res_count width = CNT_W. Comparison with thresh is unsigned.
// CONFIGURATION
//  PTS_THRESH_EN defined:
//   - at push, store res_obj = (acc_y >= thresh), thresh sampled in CAPTURE.
//  PTS_THRESH_EN undefined:
//   - res_obj tied 0; thresh ignored; no comparator or FIFO bit.
// TESTING
//  T1: frame_start, then 5 beats (hits 1,0,1,1,1) with sector_end on the 5th
//      -> res_count=4, res_sector=0, res_valid 3 cycles after the 5th beat.
//  T2: full frame, 16 sectors of 10 hits each, res_ready=1
//      -> 16 entries, sectors 0..15, count 10, busy falls after the last push.
//  T3: res_ready=0 for 6 sectors -> 4 entries queued, pt_ready held 0 in CAPTURE;
//      release res_ready -> no entries lost, order preserved.
//  T4: 2050 hits in one sector -> res_count=2047, res_ovf=1; next sector's ovf=0.
//  T5: frame_start after 3 beats of sector 2 -> no entry for sector 2,
//      next entry is sector 0 with a fresh count.
//  T6 (PTS_THRESH_EN): thresh=5; sectors with 4, 5, 6 hits -> res_obj 0, 1, 1.

Source files
------------

// File: rtl/pts_sector_sched.sv
// pts_sector_sched
//   Drives an external 11-bit point-count accumulator once per angular sector of
//   a LiDAR scan frame. ROI hits from the point stream are gated into the
//   accumulator, the total is captured at the end of each sector into a small
//   result FIFO, and the accumulator is cleared for the next sector.
//
//   Build option: define PTS_THRESH_EN to store a per-sector detection flag
//   (count >= thresh, unsigned) alongside each result. When it is undefined,
//   res_obj is tied 0 and thresh is ignored.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   frame_start           1-cycle pulse, starts (or restarts) a frame
//   pt_valid/pt_ready     point stream handshake; pt_hit counts, sector_end closes the sector
//   acc_y                 accumulator registered count
//   acc_ce/acc_rst/acc_a  accumulator enable / synchronous clear / increment bit
//   thresh                detection threshold (PTS_THRESH_EN only)
//   res_valid/res_ready   result FIFO head handshake
//   res_count/res_sector/res_ovf/res_obj   head entry fields
//   busy                  sequencer is not idle
module pts_sector_sched #(
  parameter int CNT_W       = 11,
  parameter int NUM_SECTORS = 16,
  parameter int SEC_W       = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             pt_valid,
  input  logic             pt_hit,
  input  logic             sector_end,
  output logic             pt_ready,
  input  logic [CNT_W-1:0] acc_y,
  output logic             acc_ce,
  output logic             acc_rst,
  output logic             acc_a,
  input  logic [CNT_W-1:0] thresh,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [SEC_W-1:0] res_sector,
  output logic             res_ovf,
  output logic             res_obj,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COUNT, S_SETTLE, S_CAPTURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NUM_SECTORS - 1);

  state_t           state, state_nxt;
  logic [SEC_W-1:0] sector;
  logic             ovf_flag;

  logic accepted, sat_block, push, pop, full;

  // Shift-register FIFO: entry 0 is always the head, so res_* come straight from flops.
  logic [CNT_W-1:0]      f_cnt  [FIFO_DEPTH];
  logic [SEC_W-1:0]      f_sec  [FIFO_DEPTH];
  logic [CNT_W-1:0]      sh_cnt [FIFO_DEPTH];
  logic [SEC_W-1:0]      sh_sec [FIFO_DEPTH];
  logic [CNT_W-1:0]      nx_cnt [FIFO_DEPTH];
  logic [SEC_W-1:0]      nx_sec [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] f_vld, sh_vld, nx_vld;
  logic [FIFO_DEPTH-1:0] f_ovf, sh_ovf, nx_ovf;
  logic [FIFO_DEPTH:0]   prev_vld;
  logic                  obj_in;
`ifdef PTS_THRESH_EN
  logic [FIFO_DEPTH-1:0] f_obj, sh_obj, nx_obj;
`else
  logic                  unused_thresh;
`endif

  // pt_ready is registered and high exactly in COUNT.
  assign accepted  = pt_valid & pt_ready;
  // A hit at full scale must not wrap the accumulator.
  assign sat_block = pt_hit & (acc_y == CNT_MAX);
  assign acc_ce    = accepted & ~sat_block;
  assign acc_a     = accepted & pt_hit & ~sat_block;

  assign full    = f_vld[FIFO_DEPTH-1];
  assign pop     = f_vld[0] & res_ready;
  // A pop in the same cycle frees the tail slot, so a full FIFO can still accept.
  assign push    = (state == S_CAPTURE) & (~full | pop);
  assign acc_rst = (state == S_CLEAR) | push;

`ifdef PTS_THRESH_EN
  assign obj_in = (acc_y >= thresh);
`else
  assign obj_in        = 1'b0;
  assign unused_thresh = ^thresh;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (frame_start) state_nxt = S_CLEAR;
      S_CLEAR:   state_nxt = frame_start ? S_CLEAR : S_COUNT;
      S_COUNT: begin
        if (frame_start)                 state_nxt = S_CLEAR;
        else if (accepted && sector_end) state_nxt = S_SETTLE;
      end
      S_SETTLE:  state_nxt = frame_start ? S_CLEAR : S_CAPTURE;
      S_CAPTURE: begin
        // An abort coinciding with a push still lets the push land.
        if (frame_start) state_nxt = S_CLEAR;
        else if (push)   state_nxt = (sector == LAST_SEC) ? S_IDLE : S_COUNT;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pt_ready <= 1'b0;
      busy     <= 1'b0;
      sector   <= '0;
      ovf_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      pt_ready <= (state_nxt == S_COUNT);
      busy     <= (state_nxt != S_IDLE);
      if (state == S_CLEAR) begin
        sector   <= '0;
        ovf_flag <= 1'b0;
      end else if (push) begin
        if (sector != LAST_SEC) sector <= sector + 1'b1;
        ovf_flag <= 1'b0;
      end else if (accepted && sat_block) begin
        ovf_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
      sh_cnt[i] = pop ? f_cnt[i+1] : f_cnt[i];
      sh_sec[i] = pop ? f_sec[i+1] : f_sec[i];
    end
    sh_cnt[FIFO_DEPTH-1] = pop ? '0 : f_cnt[FIFO_DEPTH-1];
    sh_sec[FIFO_DEPTH-1] = pop ? '0 : f_sec[FIFO_DEPTH-1];
    sh_vld = pop ? {1'b0, f_vld[FIFO_DEPTH-1:1]} : f_vld;
    sh_ovf = pop ? {1'b0, f_ovf[FIFO_DEPTH-1:1]} : f_ovf;
`ifdef PTS_THRESH_EN
    sh_obj = pop ? {1'b0, f_obj[FIFO_DEPTH-1:1]} : f_obj;
    nx_obj = sh_obj;
`endif
    nx_cnt   = sh_cnt;
    nx_sec   = sh_sec;
    nx_vld   = sh_vld;
    nx_ovf   = sh_ovf;
    // The write slot is the first empty entry after the pop has shifted.
    prev_vld = {sh_vld, 1'b1};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (push && !sh_vld[i] && prev_vld[i]) begin
        nx_cnt[i] = acc_y;
        nx_sec[i] = sector;
        nx_vld[i] = 1'b1;
        nx_ovf[i] = ovf_flag;
`ifdef PTS_THRESH_EN
        nx_obj[i] = obj_in;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        f_cnt[i] <= '0;
        f_sec[i] <= '0;
      end
      f_vld <= '0;
      f_ovf <= '0;
`ifdef PTS_THRESH_EN
      f_obj <= '0;
`endif
    end else begin
      f_cnt <= nx_cnt;
      f_sec <= nx_sec;
      f_vld <= nx_vld;
      f_ovf <= nx_ovf;
`ifdef PTS_THRESH_EN
      f_obj <= nx_obj;
`endif
    end
  end

  assign res_valid  = f_vld[0];
  assign res_count  = f_cnt[0];
  assign res_sector = f_sec[0];
  assign res_ovf    = f_ovf[0];
`ifdef PTS_THRESH_EN
  assign res_obj    = f_obj[0];
`else
  assign res_obj    = obj_in;
`endif

endmodule

// File: tb/tb_pts_sector_sched.sv
// Testbench for pts_sector_sched: models the external accumulator, drives
// directed sector vectors, and checks FIFO results through a scoreboard queue
// popped by an independent monitor.
module tb_pts_sector_sched;
  localparam int CNT_W = 11;
  localparam int SEC_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_start, pt_valid, pt_hit, sector_end, pt_ready;
  logic [CNT_W-1:0] acc_y;
  logic             acc_ce, acc_rst, acc_a;
  logic [CNT_W-1:0] thresh;
  logic             res_valid, res_ready;
  logic [CNT_W-1:0] res_count;
  logic [SEC_W-1:0] res_sector;
  logic             res_ovf, res_obj, busy;

  always #5 clk = ~clk;

  pts_sector_sched dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pt_valid(pt_valid),
    .pt_hit(pt_hit), .sector_end(sector_end), .pt_ready(pt_ready),
    .acc_y(acc_y), .acc_ce(acc_ce), .acc_rst(acc_rst), .acc_a(acc_a),
    .thresh(thresh), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_sector(res_sector), .res_ovf(res_ovf),
    .res_obj(res_obj), .busy(busy)
  );

  // External accumulator: synchronous clear, enable, 1-bit increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          acc_y <= '0;
    else if (acc_rst) acc_y <= '0;
    else if (acc_ce)  acc_y <= acc_y + {{(CNT_W-1){1'b0}}, acc_a};
  end

  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             obj;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic obj_exp(input logic v);
`ifdef PTS_THRESH_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares the head entry whenever the consumer pops it.
  always @(negedge clk) begin
    if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_entry: got sector %0d count %0d required none", res_sector, res_count);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("res_sector", res_sector, e.sec);
        check("res_count",  res_count,  e.cnt);
        check("res_ovf",    res_ovf,    e.ovf);
        check("res_obj",    res_obj,    e.obj);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic beat(input logic hit, input logic send);
    int n;
    n = 0;
    @(negedge clk);
    while (pt_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready", pt_ready, 1'b1);
    pt_valid   = 1'b1;
    pt_hit     = hit;
    sector_end = send;
    @(posedge clk);
    #1;
    pt_valid   = 1'b0;
    pt_hit     = 1'b0;
    sector_end = 1'b0;
  endtask

  task automatic run_sector(input int sec, input int nhits, input int nmiss,
                            input int ecnt, input logic eovf, input logic eobj);
    exp_t e;
    e.sec = SEC_W'(sec);
    e.cnt = CNT_W'(ecnt);
    e.ovf = eovf;
    e.obj = obj_exp(eobj);
    expq.push_back(e);
    for (int i = 0; i < nhits; i++) beat(1'b1, (nmiss == 0) && (i == nhits - 1));
    for (int i = 0; i < nmiss; i++) beat(1'b0, i == nmiss - 1);
  endtask

  task automatic wait_drain(input int maxcyc);
    int k;
    k = 0;
    while (expq.size() != 0 && k < maxcyc) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_pending", expq.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; pt_valid = 1'b0; pt_hit = 1'b0;
    sector_end = 1'b0; res_ready = 1'b0; thresh = CNT_W'(5);
    cycles(3);
    check("rst_busy",      busy,       0);
    check("rst_pt_ready",  pt_ready,   0);
    check("rst_res_valid", res_valid,  0);
    check("rst_res_count", res_count,  0);
    check("rst_res_sec",   res_sector, 0);
    check("rst_res_ovf",   res_ovf,    0);
    check("rst_res_obj",   res_obj,    0);
    check("rst_acc_ce",    acc_ce,     0);
    check("rst_acc_rst",   acc_rst,    0);
    @(negedge clk) rst = 1'b0;
    cycles(2);
    check("idle_busy", busy, 0);

    // T1: hits 1,0,1,1,1 -> count 4, visible three edges after the last beat
    res_ready = 1'b1;
    pulse_frame();
    check("t1_busy", busy, 1);
    run_sector(0, 0, 0, 4, 1'b0, 1'b0);
    beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    check("t1_lat_e1", res_valid, 0);
    check("t1_acc_y",  acc_y, 4);
    cycles(1);
    check("t1_lat_e2", res_valid, 0);
    check("t1_capture_ready", pt_ready, 0);
    cycles(1);
    check("t1_lat_e3", res_valid, 1);
    check("t1_count",  res_count, 4);
    wait_drain(20);

    // T2: full frame, 16 sectors of 10 hits
    pulse_frame();
    for (int s = 0; s < 16; s++) run_sector(s, 10, 0, 10, 1'b0, 1'b1);
    cycles(1);
    check("t2_busy_settle", busy, 1);
    cycles(1);
    check("t2_busy_done", busy, 0);
    check("t2_idle_ready", pt_ready, 0);
    wait_drain(40);

    // T3: consumer stalled, FIFO fills, sequencer holds in CAPTURE
    res_ready = 1'b0;
    pulse_frame();
    for (int s = 0; s < 5; s++) run_sector(s, 2, 0, 2, 1'b0, 1'b0);
    cycles(2);
    for (int k = 0; k < 6; k++) begin
      check("t3_stall_ready", pt_ready, 0);
      check("t3_stall_busy",  busy, 1);
      cycles(1);
    end
    check("t3_head_valid",  res_valid, 1);
    check("t3_head_sector", res_sector, 0);
    res_ready = 1'b1;
    run_sector(5, 2, 0, 2, 1'b0, 1'b0);
    wait_drain(40);

    // T4: saturation in sector 0, fresh ovf in sector 1
    pulse_frame();
    run_sector(0, 2050, 0, 2047, 1'b1, 1'b1);
    run_sector(1, 3, 1, 3, 1'b0, 1'b0);
    wait_drain(40);

    // T5: abort inside sector 2 discards it; restart at sector 0
    pulse_frame();
    run_sector(0, 1, 0, 1, 1'b0, 1'b0);
    run_sector(1, 1, 0, 1, 1'b0, 1'b0);
    beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    cycles(1);
    pulse_frame();
    run_sector(0, 2, 0, 2, 1'b0, 1'b0);
    wait_drain(40);

    // T6: threshold flag for counts 4, 5, 6 with thresh = 5
    pulse_frame();
    run_sector(0, 4, 0, 4, 1'b0, 1'b0);
    run_sector(1, 5, 0, 5, 1'b0, 1'b1);
    run_sector(2, 6, 0, 6, 1'b0, 1'b1);
    wait_drain(40);

    // Asynchronous reset mid-frame drops queued results
    res_ready = 1'b0;
    pulse_frame();
    beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b1);
    cycles(3);
    check("arst_pre_valid", res_valid, 1);
    check("arst_pre_count", res_count, 3);
    beat(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",      busy,      0);
    check("arst_valid",     res_valid, 0);
    check("arst_ready",     pt_ready,  0);
    check("arst_count",     res_count, 0);
    @(negedge clk) rst = 1'b0;
    res_ready = 1'b1;
    cycles(3);
    check("arst_post_valid", res_valid, 0);
    check("arst_post_busy",  busy, 0);
    check("final_queue", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
